sync_fifo_pro: RTL and testbench



---
 rtl/sync_fifo_pro.sv | 112 +++++++++++
 tb/tb_sync_fifo_pro.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_pro.sv
// sync_fifo_pro: single-clock parametrised FIFO with almost flags, count,
// optional first-word-fall-through read and sticky error flags.
module sync_fifo_pro #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int AF_GAP     = 3,
    parameter int AE_GAP     = 3,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    output logic                  wfull_almost,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty,
    output logic                  rempty_almost,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C   = (ADDR_WIDTH+1)'(DEPTH - AF_GAP);
    localparam logic [ADDR_WIDTH:0] AE_C   = (ADDR_WIDTH+1)'(AE_GAP);

    if (AF_GAP < 0 || AF_GAP >= DEPTH || AE_GAP < 0 || AE_GAP >= DEPTH) begin : g_bad_gap
        $fatal(1, "sync_fifo_pro: AF_GAP/AE_GAP must be in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  wa, ra;

    // Flags come from the registered count only, never from pointers.
    assign wfull         = (count_q == FULL_C);
    assign wfull_almost  = (count_q >= AF_C);
    assign rempty        = (count_q == '0);
    assign rempty_almost = (count_q <= AE_C);
    assign count         = count_q;
    assign overflow      = ovf_q;
    assign underflow     = unf_q;

    assign wa = winc & ~wfull & ~clr;
    assign ra = rinc & ~rempty & ~clr;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (wa) wptr_d = wptr_q + ADDR_WIDTH'(1);
            if (ra) rptr_d = rptr_q + ADDR_WIDTH'(1);
            unique case ({wa, ra})
                2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
                2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
                default: count_d = count_q;
            endcase
            if (winc & wfull)  ovf_d = 1'b1;
            if (rinc & rempty) unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wa) mem_q[wptr_q] <= wdata;
    end

    if (FWFT != 0) begin : g_fwft
        // Gate with rempty so stale storage is never presented.
        assign rdata = rempty ? '0 : mem_q[rptr_q];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rdata_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  rdata_q <= '0;
            else if (ra) rdata_q <= mem_q[rptr_q];
        end
        assign rdata = rdata_q;
    end

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Bench for sync_fifo_pro: standard and FWFT instances share stimulus and
// are checked against a queue-based reference model.
module tb_sync_fifo_pro;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic       s_wfull, s_wfa, s_rempty, s_rea, s_ovf, s_unf;
    logic [7:0] s_rdata;
    logic [8:0] s_count;
    logic       f_wfull, f_wfa, f_rempty, f_rea, f_ovf, f_unf;
    logic [7:0] f_rdata;
    logic [8:0] f_count;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q[$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;
    logic [7:0] m_rd = 8'h00;

    sync_fifo_pro #(.FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .winc(winc), .wdata(wdata),
        .wfull(s_wfull), .wfull_almost(s_wfa),
        .rinc(rinc), .rdata(s_rdata),
        .rempty(s_rempty), .rempty_almost(s_rea),
        .count(s_count), .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_pro #(.FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .winc(winc), .wdata(wdata),
        .wfull(f_wfull), .wfull_almost(f_wfa),
        .rinc(rinc), .rdata(f_rdata),
        .rempty(f_rempty), .rempty_almost(f_rea),
        .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int sz;
        logic [7:0] fexp;
        sz = q.size();
        fexp = (sz > 0) ? q[0] : 8'h00;
        chk("count_s", 32'(s_count), 32'(sz));
        chk("count_f", 32'(f_count), 32'(sz));
        chk("wfull", 32'({s_wfull, f_wfull}), {30'd0, {2{sz == 256}}});
        chk("wfull_almost", 32'({s_wfa, f_wfa}), {30'd0, {2{sz >= 253}}});
        chk("rempty", 32'({s_rempty, f_rempty}), {30'd0, {2{sz == 0}}});
        chk("rempty_almost", 32'({s_rea, f_rea}), {30'd0, {2{sz <= 3}}});
        chk("overflow", 32'({s_ovf, f_ovf}), {30'd0, {2{m_ovf}}});
        chk("underflow", 32'({s_unf, f_unf}), {30'd0, {2{m_unf}}});
        chk("rdata_std", 32'(s_rdata), 32'(m_rd));
        chk("rdata_fwft", 32'(f_rdata), 32'(fexp));
    endtask

    task automatic step(input bit w, input bit r, input bit c,
                        input logic [7:0] d);
        bit full, empty;
        @(negedge clk);
        winc = w; rinc = r; clr = c; wdata = d;
        @(posedge clk);
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            full  = (q.size() == 256);
            empty = (q.size() == 0);
            if (w && full)  m_ovf = 1'b1;
            if (r && empty) m_unf = 1'b1;
            if (r && !empty) m_rd = q.pop_front();
            if (w && !full)  q.push_back(d);
        end
        #1 check_all();
    endtask

    task automatic async_reset();
        @(negedge clk);
        winc = 1'b1; rinc = 1'b0; clr = 1'b0; wdata = 8'h77;
        #2 rst_n = 1'b0;
        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_rd = 8'h00;
        #1 check_all();
        @(negedge clk);
        winc = 1'b0;
        rst_n = 1'b1;
        #1 check_all();
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 8'($urandom));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 8'h00);
    endtask

    initial begin
        int nw, iter;
        bit w, r;

        #12 check_all();
        @(negedge clk) rst_n = 1'b1;

        for (int i = 1; i <= 256; i++) step(1, 0, 0, 8'(i));
        step(1, 0, 0, 8'hEE);
        chk("ovf_after_257", 32'(s_ovf), 32'd1);
        drain(256);
        step(0, 1, 0, 8'h00);
        chk("unf_hold_rdata", 32'(s_rdata), 32'h00);

        step(0, 0, 1, 8'h00);
        fill(256);
        step(1, 1, 0, 8'h5A);
        chk("full_wr_rd_count", 32'(s_count), 32'd255);
        drain(255);
        step(0, 0, 1, 8'h00);
        step(1, 1, 0, 8'hA5);
        chk("empty_wr_rd_count", 32'(s_count), 32'd1);
        step(0, 1, 0, 8'h00);
        chk("a5_readback", 32'(s_rdata), 32'hA5);

        step(0, 0, 1, 8'h00);
        step(1, 0, 0, 8'h00);
        nw = 1;
        iter = 0;
        while (nw < 300 && iter < 5000) begin
            w = 1'($urandom);
            r = 1'($urandom);
            if (q.size() >= 10) w = 1'b0;
            if (q.size() <= 1)  r = 1'b0;
            step(w, r, 0, 8'($urandom));
            if (w) nw++;
            iter++;
        end
        chk("wrap_budget", 32'(iter < 5000), 32'd1);
        drain(q.size());

        step(0, 0, 1, 8'h00);
        step(1, 0, 0, 8'h3C);
        chk("fwft_3c", 32'({f_rempty, f_rdata}), 32'h03C);
        step(0, 1, 0, 8'h00);
        chk("fwft_pop", 32'({f_rempty, f_rdata}), 32'h100);

        fill(256);
        step(1, 0, 0, 8'h11);
        drain(251);
        step(1, 0, 1, 8'hEE);
        chk("clr_state", 32'({s_count, s_rempty, s_ovf}), 32'b0_0000_0000_1_0);
        step(0, 1, 0, 8'h00);

        step(0, 0, 1, 8'h00);
        fill(256);
        step(1, 0, 0, 8'h22);
        drain(251);
        async_reset();
        chk("rst_state", 32'({s_count, s_rempty, s_ovf}), 32'b0_0000_0000_1_0);
        step(0, 1, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
